// File: rtl/mac_host_pkg.sv
// mac_host_pkg: shared constants and types for the mac host sequencer.
// Holds MAC_CTRL bit positions, control codes and the FSM state type.
package mac_host_pkg;

    localparam int CTRL_EN      = 7;
    localparam int CTRL_ACC_CLR = 5;
    localparam int CTRL_LOAD_B  = 2;
    localparam int CTRL_START   = 1;
    localparam int CTRL_LOAD_A  = 0;

    localparam logic [7:0] CTRL_IDLE = 8'h80;
    localparam logic [7:0] CTRL_LOAD = 8'h85;
    localparam logic [7:0] CTRL_RUN  = 8'h87;
    localparam logic [7:0] CTRL_CLR  = 8'hA0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        RESP,
        CLR
    } state_t;

endpackage

// File: rtl/mac_host_if.sv
// mac_host_if: command/response valid-ready bundle of the mac host.
// master = bus/CPU side, slave = mac_host_ctrl.
interface mac_host_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_clr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_clr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_clr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/mac_host_timer.sv
// mac_host_timer: loadable down-counter shared by CLR hold and RUN timeout.
// Ports: clk, reset, load_i/load_val_i, en_i (count down), tc_o (count==0).
module mac_host_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mac_host_ctrl.sv
// mac_host_ctrl: sequences mac LOAD/RUN/CLR for commands from host.
// Ports: clk, reset, host (slave), busy, MAC_INA/INB/CTRL, MAC_OUT, IRQ_MAC.
// Option: MAC_HOST_TIMEOUT_EN aborts RUN after TIMEOUT_CYCLES cycles.
module mac_host_ctrl
    import mac_host_pkg::*;
#(
    parameter int CLR_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    mac_host_if.slave   host,
    output logic        busy,
    output logic [31:0] MAC_INA,
    output logic [31:0] MAC_INB,
    output logic [7:0]  MAC_CTRL,
    input  logic [15:0] MAC_OUT,
    input  logic        IRQ_MAC
);

    localparam int TLOG = $clog2(TIMEOUT_CYCLES);
    localparam int TW   = (TLOG > 4) ? TLOG : 4;
    localparam logic [TW-1:0] CLR_LD = TW'(CLR_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] ina_q, ina_d;
    logic [31:0] inb_q, inb_d;
    logic        clr_q, clr_d;
    logic [15:0] data_q, data_d;
    logic        tmr_ld, tmr_en, tmr_tc;
    logic [TW-1:0] tmr_val;

`ifdef MAC_HOST_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LD = TW'(TIMEOUT_CYCLES - 1);
    logic        err_q, err_d;
`endif

    // Stale-IRQ guard: never start while the mac still flags completion.
    assign host.cmd_ready = (state_q == IDLE) && !IRQ_MAC && !reset;
    assign host.rsp_valid = (state_q == RESP);
    assign host.rsp_data  = data_q;
    assign busy           = (state_q != IDLE);
    assign MAC_INA        = ina_q;
    assign MAC_INB        = inb_q;

`ifdef MAC_HOST_TIMEOUT_EN
    assign host.rsp_err = err_q;
`else
    assign host.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ina_d   = ina_q;
        inb_d   = inb_q;
        clr_d   = clr_q;
        data_d  = data_q;
        tmr_ld  = 1'b0;
        tmr_en  = 1'b0;
        tmr_val = CLR_LD;
`ifdef MAC_HOST_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (host.cmd_valid && host.cmd_ready) begin
                    ina_d   = host.cmd_a;
                    inb_d   = host.cmd_b;
                    clr_d   = host.cmd_clr;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
`ifdef MAC_HOST_TIMEOUT_EN
                tmr_ld  = 1'b1;
                tmr_val = TO_LD;
`endif
            end
            RUN: begin
                if (IRQ_MAC) begin
                    data_d  = MAC_OUT;
                    state_d = RESP;
`ifdef MAC_HOST_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (tmr_tc) begin
                    // Abort leaves the accumulator suspect: force a clear.
                    data_d  = '0;
                    err_d   = 1'b1;
                    clr_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmr_en  = 1'b1;
`endif
                end
            end
            RESP: begin
                if (host.rsp_ready) begin
                    state_d = clr_q ? CLR : IDLE;
                    tmr_ld  = clr_q;
                end
            end
            CLR: begin
                if (tmr_tc) begin
                    state_d = IDLE;
                end else begin
                    tmr_en  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ina_q   <= '0;
            inb_q   <= '0;
            clr_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ina_q   <= ina_d;
            inb_q   <= inb_d;
            clr_q   <= clr_d;
            data_q  <= data_d;
        end
    end

`ifdef MAC_HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    always_comb begin
        unique case (state_q)
            LOAD:    MAC_CTRL = CTRL_LOAD;
            RUN:     MAC_CTRL = CTRL_RUN;
            CLR:     MAC_CTRL = CTRL_CLR;
            default: MAC_CTRL = CTRL_IDLE;
        endcase
    end

    mac_host_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_ld),
        .en_i       (tmr_en),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

endmodule

// File: tb/tb_mac_host_ctrl.sv
// tb_mac_host_ctrl: directed bench with response scoreboard and mac model.
// Build with MAC_HOST_TIMEOUT_EN to include the timeout scenario.
module tb_mac_host_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [31:0] mac_ina;
    logic [31:0] mac_inb;
    logic [7:0]  mac_ctrl;
    logic [15:0] mac_out;
    logic        irq_auto = 1'b0;
    logic        irq_stuck;
    logic        irq_mac;
    int          irq_delay;
    int          run_cnt = 0;

    int checks = 0;
    int fails  = 0;

    logic [15:0] sb_data[$];
    logic        sb_err[$];

    mac_host_if bus ();

    mac_host_ctrl #(
        .CLR_CYCLES     (2),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .host     (bus),
        .busy     (busy),
        .MAC_INA  (mac_ina),
        .MAC_INB  (mac_inb),
        .MAC_CTRL (mac_ctrl),
        .MAC_OUT  (mac_out),
        .IRQ_MAC  (irq_mac)
    );

    always #5 clk = ~clk;

    assign irq_mac = irq_auto | irq_stuck;

    // mac model: IRQ rises so that it is high in RUN cycle irq_delay.
    always @(posedge clk) begin
        if (mac_ctrl == 8'h85) begin
            run_cnt  <= 0;
            irq_auto <= 1'b0;
        end else if (mac_ctrl == 8'h87) begin
            run_cnt <= run_cnt + 1;
            if (irq_delay >= 2 && run_cnt + 2 == irq_delay) begin
                irq_auto <= 1'b1;
            end
        end else begin
            irq_auto <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Scoreboard monitor: pop and compare on each response handshake.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb_data.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rsp_unexpected act=%h exp=none",
                         bus.rsp_data);
            end else begin
                chk("rsp_data", bus.rsp_data, sb_data.pop_front());
                chk("rsp_err", bus.rsp_err, sb_err.pop_front());
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic c, input int dly,
                         input logic [15:0] mo, input logic [15:0] ed,
                         input logic ee, input bit push);
        int n;
        nxt();
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_clr   = c;
        bus.cmd_valid = 1'b1;
        irq_delay     = dly;
        mac_out       = mo;
        if (push) begin
            sb_data.push_back(ed);
            sb_err.push_back(ee);
        end
        n = 0;
        smp();
        while (!bus.cmd_ready && n < 50) begin
            nxt();
            smp();
            n++;
        end
        chk("cmd_accept", bus.cmd_ready, 1);
        nxt();
        bus.cmd_valid = 1'b0;
        smp();
        chk("load_ctrl", mac_ctrl, 8'h85);
        chk("load_ina", mac_ina, a);
        chk("load_inb", mac_inb, b);
        chk("load_busy", busy, 1);
        chk("load_cmd_ready", bus.cmd_ready, 0);
    endtask

    task automatic count_run(output int n);
        n = 0;
        nxt();
        smp();
        while (mac_ctrl == 8'h87 && n < 200) begin
            n++;
            nxt();
            smp();
        end
    endtask

    task automatic chk_resp(input logic [15:0] d, input logic e);
        chk("resp_ctrl", mac_ctrl, 8'h80);
        chk("resp_valid", bus.rsp_valid, 1);
        chk("resp_data_now", bus.rsp_data, d);
        chk("resp_err_now", bus.rsp_err, e);
    endtask

    task automatic chk_idle();
        chk("idle_ctrl", mac_ctrl, 8'h80);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int n;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_clr   = 1'b0;
        bus.rsp_ready = 1'b1;
        irq_stuck     = 1'b0;
        irq_delay     = 0;
        mac_out       = '0;

        // Reset held for 5 cycles.
        repeat (4) @(posedge clk);
        smp();
        chk("rst_ctrl", mac_ctrl, 8'h80);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ina", mac_ina, 0);
        chk("rst_inb", mac_inb, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        nxt();
        reset = 1'b0;
        smp();
        chk_idle();

        // Plain command, IRQ after 20 RUN cycles.
        issue(32'h33F08235, 32'h60B2D903, 1'b0, 20,
              16'h1234, 16'h1234, 1'b0, 1'b1);
        count_run(n);
        chk("run_len_20", n, 20);
        chk_resp(16'h1234, 1'b0);
        nxt();
        smp();
        chk_idle();

        // Clearing command: two CLR cycles after the handshake.
        issue(32'h33F08235, 32'h60B2D903, 1'b1, 20,
              16'h5678, 16'h5678, 1'b0, 1'b1);
        count_run(n);
        chk("run_len_clr", n, 20);
        chk_resp(16'h5678, 1'b0);
        nxt();
        smp();
        chk("clr1_ctrl", mac_ctrl, 8'hA0);
        chk("clr1_cmd_ready", bus.cmd_ready, 0);
        chk("clr1_busy", busy, 1);
        nxt();
        smp();
        chk("clr2_ctrl", mac_ctrl, 8'hA0);
        nxt();
        smp();
        chk_idle();

        // Back-pressured response with a second command pending.
        nxt();
        bus.rsp_ready = 1'b0;
        issue(32'h00000001, 32'hFFFFFFFF, 1'b0, 3,
              16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
        count_run(n);
        chk("run_len_3", n, 3);
        chk_resp(16'hBEEF, 1'b0);
        nxt();
        bus.cmd_a     = 32'hA5A5A5A5;
        bus.cmd_b     = 32'h5A5A5A5A;
        bus.cmd_clr   = 1'b0;
        bus.cmd_valid = 1'b1;
        irq_delay     = 2;
        mac_out       = 16'h0042;
        sb_data.push_back(16'h0042);
        sb_err.push_back(1'b0);
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_data", bus.rsp_data, 16'hBEEF);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_ina", mac_ina, 32'h00000001);
            nxt();
        end
        bus.rsp_ready = 1'b1;
        smp();
        nxt();
        smp();
        chk_idle();
        nxt();
        bus.cmd_valid = 1'b0;
        smp();
        chk("second_ctrl", mac_ctrl, 8'h85);
        chk("second_ina", mac_ina, 32'hA5A5A5A5);
        chk("second_inb", mac_inb, 32'h5A5A5A5A);
        count_run(n);
        chk("run_len_2", n, 2);
        chk_resp(16'h0042, 1'b0);
        nxt();
        smp();
        chk_idle();

        // Stale IRQ in IDLE blocks acceptance until it drops.
        nxt();
        irq_stuck     = 1'b1;
        bus.cmd_a     = 32'h0000CAFE;
        bus.cmd_b     = 32'h0000F00D;
        bus.cmd_clr   = 1'b0;
        bus.cmd_valid = 1'b1;
        irq_delay     = 4;
        mac_out       = 16'h0F0F;
        sb_data.push_back(16'h0F0F);
        sb_err.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("stuck_cmd_ready", bus.cmd_ready, 0);
            chk("stuck_busy", busy, 0);
            nxt();
        end
        irq_stuck = 1'b0;
        smp();
        chk("unstuck_cmd_ready", bus.cmd_ready, 1);
        nxt();
        bus.cmd_valid = 1'b0;
        smp();
        chk("unstuck_ctrl", mac_ctrl, 8'h85);
        chk("unstuck_ina", mac_ina, 32'h0000CAFE);
        count_run(n);
        chk("run_len_4", n, 4);
        chk_resp(16'h0F0F, 1'b0);
        nxt();
        smp();
        chk_idle();

`ifdef MAC_HOST_TIMEOUT_EN
        // IRQ never comes: abort after 64 RUN cycles, forced clear.
        issue(32'h00000011, 32'h00000022, 1'b0, 0,
              16'h7777, 16'h0000, 1'b1, 1'b1);
        count_run(n);
        chk("run_len_timeout", n, 64);
        chk_resp(16'h0000, 1'b1);
        nxt();
        smp();
        chk("to_clr1_ctrl", mac_ctrl, 8'hA0);
        nxt();
        smp();
        chk("to_clr2_ctrl", mac_ctrl, 8'hA0);
        nxt();
        smp();
        chk_idle();
`endif

        // Reset during RUN: next edge restores reset values.
        issue(32'h12345678, 32'h9ABCDEF0, 1'b1, 0,
              16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            nxt();
            smp();
            chk("pre_rst_ctrl", mac_ctrl, 8'h87);
        end
        nxt();
        reset = 1'b1;
        smp();
        chk("rst_pending_ctrl", mac_ctrl, 8'h87);
        nxt();
        smp();
        chk("midrst_ctrl", mac_ctrl, 8'h80);
        chk("midrst_busy", busy, 0);
        chk("midrst_ina", mac_ina, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        nxt();
        reset = 1'b0;
        smp();
        chk_idle();

        nxt();
        chk("sb_empty", sb_data.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
